trap_arbiter: RTL and testbench

TRAP_ARBITER -- requirements
Module: trap_arbiter

---
 rtl/trap_arbiter.sv | 270 +++++++++++++++++++++++++++
 tb/tb_trap_arbiter.sv | 543 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_arbiter.sv
// -----------------------------------------------------------------------------
// trap_arbiter
//
// Arbitrates the writeback-stage control events that need the privileged unit
// (CSR writes, MRET, synchronous exceptions and external interrupts). One
// event at a time is offered on a valid/ready request channel. MRET, EXC and
// INT are followed by a one-cycle pipeline flush. Writeback is stalled from the
// cycle an event is selected until the request is accepted.
//
// Ports
//   clk          in   single clock, rising edge
//   resetn       in   asynchronous active-low reset
//   wb_valid     in   valid instruction at writeback; gates every event
//   wb_csr_we    in   CSR write request
//   wb_csr_addr  in   CSR address          [CSR_A_W]
//   wb_csr_data  in   CSR write data       [DATA_W]
//   wb_mret      in   MRET at writeback
//   wb_exc       in   exception at writeback
//   wb_exc_code  in   exception cause      [EXC_W]
//   wb_pc        in   writeback PC         [PC_W]
//   irq_raw      in   asynchronous interrupt lines [NUM_IRQ]
//   irq_en       in   per-channel interrupt enable [NUM_IRQ]
//   gie          in   global interrupt enable
//   req_valid    out  request present
//   req_ready    in   request accepted when high together with req_valid
//   req_kind     out  0=CSRW 1=MRET 2=EXC 3=INT
//   req_code     out  exception code or interrupt channel index [EXC_W]
//   req_pc       out  trapping PC (EXC/INT only) [PC_W]
//   req_addr     out  CSR address (CSRW only) [CSR_A_W]
//   req_data     out  CSR data (CSRW only) [DATA_W]
//   stall_o      out  freeze writeback
//   flush_o      out  one-cycle redirect pulse
// -----------------------------------------------------------------------------
module trap_arbiter #(
    parameter int                 NUM_IRQ     = 3,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 PC_W        = 64,
    parameter int                 DATA_W      = 64,
    parameter int                 CSR_A_W     = 12,
    parameter int                 EXC_W       = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wb_valid,
    input  logic               wb_csr_we,
    input  logic [CSR_A_W-1:0] wb_csr_addr,
    input  logic [DATA_W-1:0]  wb_csr_data,
    input  logic               wb_mret,
    input  logic               wb_exc,
    input  logic [EXC_W-1:0]   wb_exc_code,
    input  logic [PC_W-1:0]    wb_pc,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               gie,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [1:0]         req_kind,
    output logic [EXC_W-1:0]   req_code,
    output logic [PC_W-1:0]    req_pc,
    output logic [CSR_A_W-1:0] req_addr,
    output logic [DATA_W-1:0]  req_data,
    output logic               stall_o,
    output logic               flush_o
);

    localparam logic [1:0] KIND_CSRW = 2'd0;
    localparam logic [1:0] KIND_MRET = 2'd1;
    localparam logic [1:0] KIND_EXC  = 2'd2;
    localparam logic [1:0] KIND_INT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [1:0]         req_kind_reg;
    logic [EXC_W-1:0]   req_code_reg;
    logic [PC_W-1:0]    req_pc_reg;
    logic [CSR_A_W-1:0] req_addr_reg;
    logic [DATA_W-1:0]  req_data_reg;

    // -------------------------------------------------------------------------
    // Interrupt synchroniser: SYNC_STAGES flops per line, stage 0 first.
    // -------------------------------------------------------------------------
    logic [NUM_IRQ-1:0] sync_reg [SYNC_STAGES];
    logic [NUM_IRQ-1:0] irq_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= '0;
            end
        end else begin
            sync_reg[0] <= irq_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_reg[s] <= sync_reg[s-1];
            end
        end
    end

    assign irq_sync = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Pending state. Level channels follow the synchronised line; edge channels
    // latch a synchronised rising edge until their INT request is accepted.
    // -------------------------------------------------------------------------
    logic               req_accept;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_chan
            if (EDGE_MASK[gi]) begin : g_edge
                logic prev_reg;
                logic pend_reg;
                logic rise;
                logic clr_pend;

                assign rise     = irq_sync[gi] & ~prev_reg;
                assign clr_pend = req_accept && (req_kind_reg == KIND_INT) &&
                                  (req_code_reg == EXC_W'(gi));

                // A fresh edge in the clearing cycle wins, so it is not lost.
                always_ff @(posedge clk or negedge resetn) begin
                    if (!resetn) begin
                        prev_reg <= 1'b0;
                        pend_reg <= 1'b0;
                    end else begin
                        prev_reg <= irq_sync[gi];
                        pend_reg <= rise | (pend_reg & ~clr_pend);
                    end
                end

                assign pending[gi] = pend_reg;
            end else begin : g_level
                assign pending[gi] = irq_sync[gi];
            end
            assign eligible[gi] = pending[gi] & irq_en[gi] & gie;
        end
    endgenerate

    // Lowest-index eligible channel wins: scan downward, last hit is kept.
    logic             int_any;
    logic [EXC_W-1:0] int_idx;

    always_comb begin
        int_any = 1'b0;
        int_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                int_any = 1'b1;
                int_idx = EXC_W'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Event selection (meaningful in IDLE only).
    // -------------------------------------------------------------------------
    logic               sel_any;
    logic [1:0]         sel_kind;
    logic [EXC_W-1:0]   sel_code;
    logic [PC_W-1:0]    sel_pc;
    logic [CSR_A_W-1:0] sel_addr;
    logic [DATA_W-1:0]  sel_data;

    always_comb begin
        sel_any  = 1'b0;
        sel_kind = KIND_CSRW;
        sel_code = '0;
        sel_pc   = '0;
        sel_addr = '0;
        sel_data = '0;
        if (wb_valid) begin
            if (wb_csr_we) begin
                sel_any  = 1'b1;
                sel_kind = KIND_CSRW;
                sel_addr = wb_csr_addr;
                sel_data = wb_csr_data;
            end else if (wb_mret) begin
                sel_any  = 1'b1;
                sel_kind = KIND_MRET;
            end else if (wb_exc) begin
                sel_any  = 1'b1;
                sel_kind = KIND_EXC;
                sel_code = wb_exc_code;
                sel_pc   = wb_pc;
            end else if (int_any) begin
                sel_any  = 1'b1;
                sel_kind = KIND_INT;
                sel_code = int_idx;
                sel_pc   = wb_pc;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    logic stall_comb;
    logic flush_comb;

    always_comb begin
        state_next = state_reg;
        stall_comb = 1'b0;
        flush_comb = 1'b0;
        req_accept = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // req_ready is ignored here; nothing is being offered.
                if (sel_any) begin
                    state_next = ST_REQ;
                    stall_comb = 1'b1;
                end
            end
            ST_REQ: begin
                stall_comb = 1'b1;
                if (req_ready) begin
                    req_accept = 1'b1;
                    state_next = (req_kind_reg == KIND_CSRW) ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush_comb = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            req_kind_reg <= KIND_CSRW;
            req_code_reg <= '0;
            req_pc_reg   <= '0;
            req_addr_reg <= '0;
            req_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && sel_any) begin
                req_kind_reg <= sel_kind;
                req_code_reg <= sel_code;
                req_pc_reg   <= sel_pc;
                req_addr_reg <= sel_addr;
                req_data_reg <= sel_data;
            end
        end
    end

    assign req_valid = (state_reg == ST_REQ);
    assign req_kind  = req_kind_reg;
    assign req_code  = req_code_reg;
    assign req_pc    = req_pc_reg;
    assign req_addr  = req_addr_reg;
    assign req_data  = req_data_reg;
    // The IDLE stall is combinational on writeback inputs, so it is masked
    // by reset explicitly; the registered outputs are cleared by the flops.
    assign stall_o   = stall_comb & resetn;
    assign flush_o   = flush_comb;

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;

    localparam int             NUM_IRQ     = 3;
    localparam logic [2:0]     EDGE_MASK   = 3'b001;
    localparam int             SYNC_STAGES = 2;
    localparam int             PC_W        = 64;
    localparam int             DATA_W      = 64;
    localparam int             CSR_A_W     = 12;
    localparam int             EXC_W       = 4;

    logic               clk;
    logic               resetn;
    logic               wb_valid;
    logic               wb_csr_we;
    logic [CSR_A_W-1:0] wb_csr_addr;
    logic [DATA_W-1:0]  wb_csr_data;
    logic               wb_mret;
    logic               wb_exc;
    logic [EXC_W-1:0]   wb_exc_code;
    logic [PC_W-1:0]    wb_pc;
    logic [NUM_IRQ-1:0] irq_raw;
    logic [NUM_IRQ-1:0] irq_en;
    logic               gie;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_kind;
    logic [EXC_W-1:0]   req_code;
    logic [PC_W-1:0]    req_pc;
    logic [CSR_A_W-1:0] req_addr;
    logic [DATA_W-1:0]  req_data;
    logic               stall_o;
    logic               flush_o;

    trap_arbiter #(
        .NUM_IRQ    (NUM_IRQ),
        .EDGE_MASK  (EDGE_MASK),
        .SYNC_STAGES(SYNC_STAGES),
        .PC_W       (PC_W),
        .DATA_W     (DATA_W),
        .CSR_A_W    (CSR_A_W),
        .EXC_W      (EXC_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wb_valid   (wb_valid),
        .wb_csr_we  (wb_csr_we),
        .wb_csr_addr(wb_csr_addr),
        .wb_csr_data(wb_csr_data),
        .wb_mret    (wb_mret),
        .wb_exc     (wb_exc),
        .wb_exc_code(wb_exc_code),
        .wb_pc      (wb_pc),
        .irq_raw    (irq_raw),
        .irq_en     (irq_en),
        .gie        (gie),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_code   (req_code),
        .req_pc     (req_pc),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .stall_o    (stall_o),
        .flush_o    (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]         kind;
        logic [EXC_W-1:0]   code;
        logic [PC_W-1:0]    pc;
        logic [CSR_A_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } txn_t;

    txn_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic txn_t observed();
        return {req_kind, req_code, req_pc, req_addr, req_data};
    endfunction

    function automatic txn_t mk(input logic [1:0] k, input logic [EXC_W-1:0] c,
                                input logic [PC_W-1:0] p, input logic [CSR_A_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        return {k, c, p, a, d};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_wb();
        wb_valid    = 1'b0;
        wb_csr_we   = 1'b0;
        wb_csr_addr = '0;
        wb_csr_data = '0;
        wb_mret     = 1'b0;
        wb_exc      = 1'b0;
        wb_exc_code = '0;
        wb_pc       = '0;
    endtask

    // Waits (bounded) for req_valid; reports how many cycles it took.
    task automatic wait_valid(input int budget, output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (req_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------------
    task automatic test_reset();
        txn_t o;
        resetn = 1'b0;
        clear_wb();
        req_ready = 1'b0;
        irq_raw = '0;
        irq_en = '0;
        gie = 1'b0;
        tick();
        wb_valid  = 1'b1;
        wb_csr_we = 1'b1;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_req_valid: got %b want 0", req_valid);
        end
        n_cmp++;
        if (stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        n_cmp++;
        if (flush_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flush: got %b want 0", flush_o);
        end
        o = observed();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_fields: got %h want 0", o);
        end
        tick();
        clear_wb();
        resetn = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_idle_ready();
        int seen;
        seen = 0;
        req_ready = 1'b1;
        repeat (5) begin
            tick();
            seen += int'(req_valid) + int'(flush_o);
        end
        req_ready = 1'b0;
        n_cmp++;
        if (seen !== 0) begin
            n_bad++;
            $display("FAIL idle_ready: got %0d activity cycles want 0", seen);
        end
        $display("test_idle_ready: done");
    endtask

    task automatic test_csrw();
        bit ok;
        int cyc;
        int nfl;
        txn_t e;
        txn_t o;
        wb_valid    = 1'b1;
        wb_csr_we   = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = 4'd3;
        wb_pc       = 64'h1234;
        wb_csr_addr = 12'h300;
        wb_csr_data = 64'h8;
        sb.push_back(mk(2'd0, '0, '0, 12'h300, 64'h8));
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL csrw_idle_stall: got %b want 1", stall_o);
        end
        wait_valid(4, ok, cyc);
        clear_wb();
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL csrw_timeout: got no req_valid want req_valid");
        end
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL csrw_fields: got %h want %h", o, e);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        nfl = int'(flush_o);
        n_cmp++;
        if (req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL csrw_accept: got req_valid %b want 0", req_valid);
        end
        repeat (3) begin
            tick();
            nfl += int'(flush_o);
        end
        n_cmp++;
        if (nfl !== 0) begin
            n_bad++;
            $display("FAIL csrw_no_flush: got %0d flush cycles want 0", nfl);
        end
        $display("test_csrw: kind=%0d addr=%h data=%h", o.kind, o.addr, o.data);
    endtask

    task automatic test_level_int();
        bit ok;
        int cyc;
        int nfl;
        txn_t e;
        txn_t o;
        gie      = 1'b1;
        irq_en   = 3'b111;
        irq_raw  = 3'b110;
        wb_valid = 1'b1;
        wb_pc    = 64'h1000;
        sb.push_back(mk(2'd3, 4'd1, 64'h1000, '0, '0));
        wait_valid(10, ok, cyc);
        clear_wb();
        irq_raw = '0;
        n_cmp++;
        if (!ok || cyc !== SYNC_STAGES + 1) begin
            n_bad++;
            $display("FAIL level_latency: got ok=%b cycles=%0d want %0d", ok, cyc, SYNC_STAGES + 1);
        end
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL level_fields: got %h want %h", o, e);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        nfl = int'(flush_o);
        repeat (3) begin
            tick();
            nfl += int'(flush_o);
        end
        n_cmp++;
        if (nfl !== 1) begin
            n_bad++;
            $display("FAIL level_flush: got %0d flush cycles want 1", nfl);
        end
        gie = 1'b0;
        repeat (3) tick();
        $display("test_level_int: kind=%0d code=%0d latency=%0d", o.kind, o.code, cyc);
    endtask

    task automatic test_edge_gie();
        bit ok;
        int cyc;
        int nfl;
        int early;
        int again;
        txn_t e;
        txn_t o;
        gie      = 1'b0;
        irq_en   = 3'b111;
        wb_valid = 1'b1;
        wb_pc    = 64'h2000;
        irq_raw  = 3'b001;
        tick();
        irq_raw  = '0;
        early = 0;
        repeat (10) begin
            tick();
            early += int'(req_valid);
        end
        n_cmp++;
        if (early !== 0) begin
            n_bad++;
            $display("FAIL edge_gie_off: got %0d req cycles want 0", early);
        end
        gie = 1'b1;
        sb.push_back(mk(2'd3, 4'd0, 64'h2000, '0, '0));
        wait_valid(4, ok, cyc);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL edge_timeout: got no req_valid want req_valid");
        end
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL edge_fields: got %h want %h", o, e);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        nfl = int'(flush_o);
        repeat (3) begin
            tick();
            nfl += int'(flush_o);
        end
        n_cmp++;
        if (nfl !== 1) begin
            n_bad++;
            $display("FAIL edge_flush: got %0d flush cycles want 1", nfl);
        end
        again = 0;
        repeat (12) begin
            tick();
            again += int'(req_valid);
        end
        n_cmp++;
        if (again !== 0) begin
            n_bad++;
            $display("FAIL edge_pending_cleared: got %0d req cycles want 0", again);
        end
        clear_wb();
        gie = 1'b0;
        tick();
        $display("test_edge_gie: kind=%0d code=%0d", o.kind, o.code);
    endtask

    task automatic test_exc_stall();
        bit ok;
        int cyc;
        int nfl;
        txn_t e;
        txn_t o;
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = 4'd2;
        wb_pc       = 64'h8000_0010;
        sb.push_back(mk(2'd2, 4'd2, 64'h8000_0010, '0, '0));
        wait_valid(4, ok, cyc);
        clear_wb();
        wb_pc = 64'hDEAD_BEEF;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL exc_timeout: got no req_valid want req_valid");
        end
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            o = observed();
            n_cmp++;
            if (o !== e || req_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL exc_hold%0d: got valid=%b %h want valid=1 %h", i, req_valid, o, e);
            end
            n_cmp++;
            if (stall_o !== 1'b1) begin
                n_bad++;
                $display("FAIL exc_stall%0d: got %b want 1", i, stall_o);
            end
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        nfl = int'(flush_o);
        repeat (3) begin
            tick();
            nfl += int'(flush_o);
        end
        n_cmp++;
        if (nfl !== 1) begin
            n_bad++;
            $display("FAIL exc_flush: got %0d flush cycles want 1", nfl);
        end
        wb_pc = '0;
        $display("test_exc_stall: kind=%0d code=%0d pc=%h", e.kind, e.code, e.pc);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int nfl;
        txn_t e;
        txn_t o;
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = 4'd5;
        wb_pc       = 64'h3000;
        sb.push_back(mk(2'd2, 4'd5, 64'h3000, '0, '0));
        wait_valid(4, ok, cyc);
        wb_exc      = 1'b0;
        wb_exc_code = '0;
        wb_pc       = 64'h3004;
        gie         = 1'b1;
        irq_en      = 3'b111;
        irq_raw     = 3'b100;
        sb.push_back(mk(2'd3, 4'd2, 64'h3004, '0, '0));
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!ok || o !== e) begin
            n_bad++;
            $display("FAIL b2b_exc: got ok=%b %h want %h", ok, o, e);
        end
        repeat (4) tick();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if (flush_o !== 1'b1 || stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_flush_state: got flush=%b stall=%b want flush=1 stall=0", flush_o, stall_o);
        end
        wait_valid(4, ok, cyc);
        clear_wb();
        irq_raw = '0;
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!ok || o !== e) begin
            n_bad++;
            $display("FAIL b2b_int: got ok=%b %h want %h", ok, o, e);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        nfl = int'(flush_o);
        repeat (3) begin
            tick();
            nfl += int'(flush_o);
        end
        n_cmp++;
        if (nfl !== 1) begin
            n_bad++;
            $display("FAIL b2b_int_flush: got %0d flush cycles want 1", nfl);
        end
        gie = 1'b0;
        repeat (3) tick();
        $display("test_back_to_back: int code=%0d pc=%h", o.code, o.pc);
    endtask

    task automatic test_reset_mid_req();
        bit ok;
        int cyc;
        int act;
        txn_t e;
        txn_t o;
        gie     = 1'b0;
        irq_en  = 3'b111;
        irq_raw = 3'b001;
        tick();
        irq_raw = '0;
        repeat (3) tick();
        wb_valid    = 1'b1;
        wb_exc      = 1'b1;
        wb_exc_code = 4'd7;
        wb_pc       = 64'h4000;
        sb.push_back(mk(2'd2, 4'd7, 64'h4000, '0, '0));
        wait_valid(4, ok, cyc);
        clear_wb();
        e = sb.pop_front();
        o = observed();
        n_cmp++;
        if (!ok || o !== e) begin
            n_bad++;
            $display("FAIL rst_mid_req_setup: got ok=%b %h want %h", ok, o, e);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (req_valid !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: got valid=%b stall=%b flush=%b want 0 0 0", req_valid, stall_o, flush_o);
        end
        tick();
        tick();
        resetn = 1'b1;
        o = observed();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL rst_fields: got %h want 0", o);
        end
        gie      = 1'b1;
        wb_valid = 1'b1;
        wb_pc    = 64'h5000;
        act = 0;
        repeat (12) begin
            tick();
            act += int'(req_valid) + int'(flush_o);
        end
        n_cmp++;
        if (act !== 0) begin
            n_bad++;
            $display("FAIL rst_pending_cleared: got %0d activity cycles want 0", act);
        end
        clear_wb();
        gie = 1'b0;
        tick();
        $display("test_reset_mid_req: done");
    endtask

    initial begin
        test_reset();
        test_idle_ready();
        test_csrw();
        test_level_int();
        test_edge_gie();
        test_exc_stall();
        test_back_to_back();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want $finish before 200000");
        $fatal(1);
    end

endmodule
